alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Parametrised, registered successor to the combinational ALU control decoder in the EX stage of the MIPS pipeline. It decodes `alu_op_idex`/`func_idex` into an ALU control code, and registers that code once per accepted instruction. It adds an optional extended operation set (OR, SLT, NOR, MULT, DIV). Multi-cycle MULT/DIV are sequenced with a start pulse, a cycle counter and a pipeline stall back to IF/ID/ID-EX.

## Interface
- `FUNC_W`, 6: width of the function field.
- `CTRL_W`, 4: width of the ALU control code; must be ≥4.
- `EXT_OPS`, 1: 1 enables OR/SLT/NOR/MULT/DIV decode; 0 decodes them as the default ADD.
- `MUL_CYCLES`, 4: stall length for MULT; must be ≥1.
- `DIV_CYCLES`, 8: stall length for DIV; must be ≥1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush from hazard unit.
- `valid_in`  in  1  ID/EX holds a valid instruction.
- `func_idex`  in  FUNC_W  function field from ID/EX.
- `alu_op_idex`  in  2  ALU op class from ID/EX.
- `alu_control`  out  CTRL_W  registered ALU control code.
- `ctrl_valid`  out  1  `alu_control` belongs to an instruction accepted at the last edge.
- `md_start`  out  1  one-cycle start pulse to the mult/div unit.
- `md_done`  out  1  one-cycle pulse when the multi-cycle operation completes.
- `stall`  out  1  freeze upstream stages; registered.

## Operation
- **Decode** (codes zero-extended to CTRL_W):
  - `alu_op` 00 → ADD 0010.
  - `alu_op` 01 → SUB 0110.
  - `alu_op` 11 → ADD 0010.
  - `alu_op` 10 with `func`:
    - 000000 → ADD 0010; 000001 → SUB 0110; 000010 → AND 0000.
    - With EXT_OPS=1: 000011 → OR 0001; 000100 → SLT 0111; 000101 → NOR 1100; 011000 → MULT 1000; 011010 → DIV 1001.
    - Any other func, or any extended code with EXT_OPS=0 → ADD 0010.
  - Only MULT/DIV are multi-cycle.
- **States:** IDLE, BUSY. The counter width is `$clog2(max(MUL_CYCLES,DIV_CYCLES))`, minimum 1.
- **Accept:** `valid_in`=1 and `stall`=0 at an edge. Inputs are ignored when not accepted; upstream holds the next instruction while `stall`=1.
- **IDLE, single-cycle op accepted:**
  - `alu_control` ← decode; `ctrl_valid` ← 1.
  - Stay in IDLE.
- **IDLE, MULT/DIV accepted:**
  - `alu_control` ← 1000 or 1001; `ctrl_valid` ← 1; `md_start` ← 1; `stall` ← 1.
  - count ← LAT-1, where LAT is MUL_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- **IDLE, nothing accepted:** `ctrl_valid` ← 0. `alu_control` holds its last value.
- **BUSY:**
  - `md_start` ← 0, `ctrl_valid` ← 0, `alu_control` held.
  - If count==0: `stall` ← 0, `md_done` ← 1, go to IDLE.
  - Else count ← count-1.
- `md_done` and `md_start` are high for exactly one cycle per operation.
- **Priority:** `rst`=0 > `flush` > accept.
- **Flush** (any state): IDLE, count ← 0, `alu_control` ← 0000. `ctrl_valid`, `md_start`, `md_done`, `stall` ← 0. No `md_done` for an aborted operation.

## Timing
- **Reset values:** `alu_control`=0000, all single-bit outputs=0, state=IDLE, count=0. Reset applied mid-BUSY aborts identically to flush.
- **Single-cycle op:** accepted at edge E; code and `ctrl_valid` are visible after E (latency 1). Back-to-back accepts yield a new code every cycle.
- **Multi-cycle op:** accepted at E.
  - `stall` is high for exactly LAT cycles, from E to E+LAT.
  - `md_start` is high E to E+1.
  - `md_done` is high E+LAT to E+LAT+1.
  - The next instruction is accepted at E+LAT+1 at the earliest.
- **LAT=1:** one stall cycle. `md_start` and `md_done` never overlap.
- **Flush coincident with `valid_in`:** the instruction is dropped.
- **Flush at the count==0 edge:** no `md_done`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `valid_in`=1, `func`=000001 → all outputs 0, `alu_control`=0000. Release → next accept works.
- **Single-cycle decode:** with EXT_OPS=1, stream `alu_op`=10 with `func` 000000/000001/000010/000011/000100/000101/111111, then `alu_op` 00/01/11, all back-to-back → `alu_control` 0010/0110/0000/0001/0111/1100/0010/0010/0110/0010, one cycle after each input. `ctrl_valid` is continuously 1 and `stall` stays 0.
- **MULT:** MUL_CYCLES=4; MULT at edge E followed by ADD held on the inputs →
  - `alu_control`=1000 from E.
  - `stall` high for exactly 4 cycles; `md_start` 1 cycle at E; `md_done` at E+4.
  - ADD is accepted at E+5, giving 0010.
- **DIV flushed mid-operation:** DIV_CYCLES=8; DIV, then `flush` at E+3 → `stall` low after E+3, `alu_control`=0000, no `md_done`. A following SUB is accepted normally, giving 0110.
- **EXT_OPS=0:** `func` 000011/011000 → 0010, and no stall or `md_start` ever occurs.
- **Reset during BUSY:** `rst`=0 at E+2 of a MULT → all outputs return to reset values at the next edge, with no `md_done`.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered EX-stage ALU control decoder with optional extended ops and
// multi-cycle MULT/DIV sequencing (start pulse, countdown, upstream stall).
module alu_control_seq #(
    parameter int FUNC_W     = 6,
    parameter int CTRL_W     = 4,
    parameter int EXT_OPS    = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [FUNC_W-1:0] func_idex,
    input  logic [1:0]        alu_op_idex,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ctrl_valid,
    output logic              md_start,
    output logic              md_done,
    output logic              stall
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MULT = 4'b1000;
    localparam logic [3:0] C_DIV  = 4'b1001;
    localparam logic [3:0] C_NOR  = 4'b1100;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Unknown function codes, and extended codes when disabled, fall back to ADD.
    function automatic logic [3:0] decode(input logic [1:0] op, input logic [FUNC_W-1:0] fn);
        logic [3:0] code;
        code = C_ADD;
        case (op)
            2'b00: code = C_ADD;
            2'b01: code = C_SUB;
            2'b10: begin
                if (fn == FUNC_W'(6'b000000))                      code = C_ADD;
                else if (fn == FUNC_W'(6'b000001))                 code = C_SUB;
                else if (fn == FUNC_W'(6'b000010))                 code = C_AND;
                else if (EXT_OPS != 0 && fn == FUNC_W'(6'b000011)) code = C_OR;
                else if (EXT_OPS != 0 && fn == FUNC_W'(6'b000100)) code = C_SLT;
                else if (EXT_OPS != 0 && fn == FUNC_W'(6'b000101)) code = C_NOR;
                else if (EXT_OPS != 0 && fn == FUNC_W'(6'b011000)) code = C_MULT;
                else if (EXT_OPS != 0 && fn == FUNC_W'(6'b011010)) code = C_DIV;
                else                                               code = C_ADD;
            end
            default: code = C_ADD;
        endcase
        return code;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              md_start_q, md_start_d;
    logic              md_done_q, md_done_d;
    logic              stall_q, stall_d;

    logic [3:0]        dec_code;
    logic              accept;

    // Next-state and output decision; flush overrides any accept.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        ctrl_valid_d = 1'b0;
        md_start_d   = 1'b0;
        md_done_d    = 1'b0;
        stall_d      = stall_q;
        dec_code     = decode(alu_op_idex, func_idex);
        accept       = valid_in & ~stall_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_d       = CTRL_W'(dec_code);
                        ctrl_valid_d = 1'b1;
                        if (dec_code == C_MULT || dec_code == C_DIV) begin
                            md_start_d = 1'b1;
                            stall_d    = 1'b1;
                            cnt_d      = (dec_code == C_MULT) ? MUL_LOAD : DIV_LOAD;
                            state_d    = BUSY;
                        end else begin
                            stall_d = 1'b0;
                        end
                    end else begin
                        stall_d = 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        stall_d   = 1'b0;
                        md_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        stall_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    stall_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            md_start_q   <= 1'b0;
            md_done_q    <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            md_start_q   <= md_start_d;
            md_done_q    <= md_done_d;
            stall_q      <= stall_d;
        end
    end

    assign alu_control = ctrl_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign md_start    = md_start_q;
    assign md_done     = md_done_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table plus multi-cycle, flush,
// reset and parameter-variant sequences on three instances sharing inputs.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       valid_in = 1'b0;
    logic [5:0] func_idex = 6'b000000;
    logic [1:0] alu_op_idex = 2'b00;

    logic [3:0] ctl_a, ctl_b, ctl_c;
    logic       cv_a, cv_b, cv_c;
    logic       ms_a, ms_b, ms_c;
    logic       md_a, md_b, md_c;
    logic       st_a, st_b, st_c;

    int n_cmp  = 0;
    int n_fail = 0;
    logic seen_b = 1'b0;

    always #5 clk = ~clk;

    alu_control_seq #(.FUNC_W(6), .CTRL_W(4), .EXT_OPS(1), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .func_idex(func_idex),
        .alu_op_idex(alu_op_idex), .alu_control(ctl_a), .ctrl_valid(cv_a), .md_start(ms_a),
        .md_done(md_a), .stall(st_a));

    alu_control_seq #(.FUNC_W(6), .CTRL_W(4), .EXT_OPS(0), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .func_idex(func_idex),
        .alu_op_idex(alu_op_idex), .alu_control(ctl_b), .ctrl_valid(cv_b), .md_start(ms_b),
        .md_done(md_b), .stall(st_b));

    alu_control_seq #(.FUNC_W(6), .CTRL_W(4), .EXT_OPS(1), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .func_idex(func_idex),
        .alu_op_idex(alu_op_idex), .alu_control(ctl_c), .ctrl_valid(cv_c), .md_start(ms_c),
        .md_done(md_c), .stall(st_c));

    // The EXT_OPS=0 instance must never stall or start the mult/div unit.
    always @(negedge clk) begin
        if (rst && (st_b === 1'b1 || ms_b === 1'b1)) seen_b <= 1'b1;
    end

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
        valid_in    = v;
        alu_op_idex = op;
        func_idex   = fn;
    endtask

    task automatic chk_a_all(input string name, input logic [3:0] c, input logic v,
                             input logic s, input logic d, input logic st);
        chk({name, ".alu_control"}, 32'(ctl_a), 32'(c));
        chk({name, ".ctrl_valid"},  32'(cv_a),  32'(v));
        chk({name, ".md_start"},    32'(ms_a),  32'(s));
        chk({name, ".md_done"},     32'(md_a),  32'(d));
        chk({name, ".stall"},       32'(st_a),  32'(st));
    endtask

    initial begin
        int stall_cnt;
        int done_cnt;

        vecs[0] = '{2'b10, 6'b000000, 4'b0010};
        vecs[1] = '{2'b10, 6'b000001, 4'b0110};
        vecs[2] = '{2'b10, 6'b000010, 4'b0000};
        vecs[3] = '{2'b10, 6'b000011, 4'b0001};
        vecs[4] = '{2'b10, 6'b000100, 4'b0111};
        vecs[5] = '{2'b10, 6'b000101, 4'b1100};
        vecs[6] = '{2'b10, 6'b111111, 4'b0010};
        vecs[7] = '{2'b00, 6'b000101, 4'b0010};
        vecs[8] = '{2'b01, 6'b000011, 4'b0110};
        vecs[9] = '{2'b11, 6'b000001, 4'b0010};

        // Reset held with a valid SUB on the inputs.
        rst = 1'b0;
        drive(1'b1, 2'b10, 6'b000001);
        step();
        step();
        chk_a_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk("post_reset.alu_control", 32'(ctl_a), 32'h6);
        chk("post_reset.ctrl_valid", 32'(cv_a), 32'h1);

        // Back-to-back single-cycle decode.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].fn);
            step();
            chk($sformatf("decode[%0d].alu_control", i), 32'(ctl_a), 32'(vecs[i].exp));
            chk($sformatf("decode[%0d].ctrl_valid", i), 32'(cv_a), 32'h1);
            chk($sformatf("decode[%0d].stall", i), 32'(st_a), 32'h0);
        end

        // MULT followed by ADD held on the inputs.
        drive(1'b1, 2'b10, 6'b011000);
        step();
        chk_a_all("mult.E", 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2'b10, 6'b000000);
        stall_cnt = 1;
        done_cnt  = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (st_a === 1'b1) stall_cnt++;
            if (md_a === 1'b1) done_cnt++;
            chk($sformatf("mult.E+%0d.alu_control", k), 32'(ctl_a), 32'h8);
            chk($sformatf("mult.E+%0d.md_start", k), 32'(ms_a), 32'h0);
            chk($sformatf("mult.E+%0d.ctrl_valid", k), 32'(cv_a), 32'h0);
        end
        chk("mult.E+4.md_done", 32'(md_a), 32'h1);
        chk("mult.E+4.stall", 32'(st_a), 32'h0);
        chk("mult.stall_cycles", 32'(stall_cnt), 32'd4);
        chk("mult.done_pulses", 32'(done_cnt), 32'd1);
        step();
        chk_a_all("mult.E+5", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);

        // DIV flushed at E+3 with a coincident valid SUB, which must be dropped.
        drive(1'b1, 2'b10, 6'b011010);
        step();
        chk_a_all("div.E", 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 6'b000000);
        step();
        step();
        chk("div.E+2.stall", 32'(st_a), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_a_all("div.flush", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_a_all("div.sub_after", 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 6'b000000);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (md_a === 1'b1) done_cnt++;
        end
        chk("div.no_md_done", 32'(done_cnt), 32'd0);
        chk("idle.ctrl_valid", 32'(cv_a), 32'h0);
        chk("idle.alu_control_held", 32'(ctl_a), 32'h6);

        // Flush exactly at the count==0 edge suppresses md_done.
        drive(1'b1, 2'b10, 6'b011000);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        step();
        step();
        step();
        chk("mflush.E+3.stall", 32'(st_a), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_a_all("mflush.E+4", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("mflush.E+5.md_done", 32'(md_a), 32'h0);

        // Reset at E+2 of a MULT aborts without md_done.
        drive(1'b1, 2'b10, 6'b011000);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_a_all("rst_busy", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (md_a === 1'b1) done_cnt++;
        end
        chk("rst_busy.no_md_done", 32'(done_cnt), 32'd0);

        // EXT_OPS=0 decodes extended functions as ADD; LAT=1 instance checked too.
        drive(1'b1, 2'b10, 6'b000011);
        step();
        chk("ext0.or.alu_control", 32'(ctl_b), 32'h2);
        chk("ext0.or.ctrl_valid", 32'(cv_b), 32'h1);
        chk("lat1.or.alu_control", 32'(ctl_c), 32'h1);
        drive(1'b1, 2'b10, 6'b011000);
        step();
        chk("ext0.mult.alu_control", 32'(ctl_b), 32'h2);
        chk("ext0.mult.stall", 32'(st_b), 32'h0);
        chk("lat1.E.alu_control", 32'(ctl_c), 32'h8);
        chk("lat1.E.md_start", 32'(ms_c), 32'h1);
        chk("lat1.E.md_done", 32'(md_c), 32'h0);
        chk("lat1.E.stall", 32'(st_c), 32'h1);
        drive(1'b0, 2'b00, 6'b000000);
        step();
        chk("lat1.E+1.md_start", 32'(ms_c), 32'h0);
        chk("lat1.E+1.md_done", 32'(md_c), 32'h1);
        chk("lat1.E+1.stall", 32'(st_c), 32'h0);
        step();
        chk("lat1.E+2.md_done", 32'(md_c), 32'h0);
        drive(1'b1, 2'b10, 6'b011010);
        step();
        chk("ext0.div.alu_control", 32'(ctl_b), 32'h2);
        drive(1'b0, 2'b00, 6'b000000);
        for (int k = 0; k < 10; k++) step();
        chk("ext0.never_stalled", 32'(seen_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
